bulls_cows_solver: RTL and testbench
====================================

# bulls_cows_solver

Automatic guesser for the 1A2B (bulls-and-cows) game, and the initiator counterpart of the game's answer checker. The block proposes 4-digit BCD guesses, consumes the `{A, 4'hA, B, 4'hB}` response word the checker produces, keeps a guess/response history, and scans candidates until the secret is found, the responses become inconsistent, or the guess budget is exhausted. It sits between the game core and the debug/auto-play mode switch.

## Interface
- `MAX_HIST`, default 10: guess budget and history depth, matching the 10-life HP bar.
- `clk  in  1`: system clock.
- `rst  in  1`: synchronous, active-high reset.
- `start  in  1`: one-cycle pulse that begins a new game.
- `guess_valid  out  1`: `guess` is offered.
- `guess_ready  in  1`: the game accepts the guess.
- `guess  out  16`: four BCD digits, `[15:12]` most significant.
- `resp_valid  in  1`: `resp` is valid.
- `resp  in  16`: `{A, 4'hA, B, 4'hB}`. Only `resp[15:12]` (A) and `resp[7:4]` (B) are used; the marker nibbles are ignored.
- `busy  out  1`: a game is in progress.
- `solved  out  1`: sticky; the last response had A==4.
- `fail  out  1`: sticky; the block gave up.
- `guess_count  out  4`: number of accepted guesses.

## Operation
- States:
  - IDLE
  - SCAN
  - OFFER
  - WAIT_RESP
  - SOLVED
  - FAIL
- IDLE/SOLVED/FAIL + `start`:
  - clear history, `guess_count`, `solved` and `fail`;
  - set `cand=0000`, `idx=0`;
  - go to SCAN.
- `start` in SCAN, OFFER or WAIT_RESP is ignored.
- SCAN evaluates one (cand, hist[idx]) pair per cycle using `score_1a2b(cand, hist_guess[idx])`:
  - History empty, or `idx==hist_cnt-1` with a match: cand is accepted, `guess<=cand`, go to OFFER.
  - Match with more entries left: `idx++`.
  - Mismatch: cand is advanced by a BCD increment (digit 9 wraps to 0 and carries), `idx=0`.
  - Advance past 9999: go to FAIL.
- OFFER: `guess_valid=1`. When `guess_valid && guess_ready`, `guess_count++` and go to WAIT_RESP. `guess` is stable while it is offered.
- WAIT_RESP on `resp_valid`:
  - A+B>4: go to FAIL.
  - A==4: go to SOLVED.
  - Otherwise push (guess, A, B) into the history, then:
    - history full (`hist_cnt==MAX_HIST`): FAIL;
    - guess==9999: FAIL;
    - else `cand=guess+1` (BCD), `idx=0`, go to SCAN.
  - Earlier candidates are already eliminated, so the scan is monotonic.
- `resp_valid` outside WAIT_RESP is ignored.
- Scoring:
  - A = number of equal positions.
  - B = sum over digit values v=0..9 of min(count of v in non-bull guess digits, count of v in non-bull candidate digits).
  - Repeated digits are legal.
- `busy=1` in SCAN, OFFER and WAIT_RESP.

## Timing
- Reset values:
  - state IDLE;
  - `guess=0`, `guess_valid=0`;
  - `busy=0`, `solved=0`, `fail=0`;
  - `guess_count=0`;
  - history count 0.
- `rst` mid-operation aborts immediately. Outputs hold their reset values from the next edge.
- `start` sampled at edge k gives SCAN at k+1. With an empty history, `guess_valid=1` from k+2.
- Each SCAN cycle costs 1 clock. Latency from response to the next `guess_valid` is (pairs evaluated)+1.
- `solved` and `fail` assert the cycle after the deciding `resp_valid`.
- A candidate never advances in the same cycle that OFFER or WAIT_RESP is active.

## Configuration
- `SOLVER_DISTINCT_EN`:
  - Defined: candidates with any repeated digit are rejected in one SCAN cycle regardless of `idx`. The first guess is therefore 0123.
  - Undefined: all 10000 BCD values are candidates. The first guess is 0000.

## Structure
- `solver_pkg`:
  - state enum;
  - BCD digit typedef;
  - response field positions (`A_MSB`, `B_MSB`);
  - marker constants 4'hA and 4'hB;
  - `MAX_HIST` default.
- Sub-module `score_1a2b`: combinational, two 16-bit BCD inputs, 3-bit A and B outputs.
- History is a `MAX_HIST`-deep register array of {guess, A, B}.

## Test plan
- Reset, then `start` with `guess_ready=1`: `guess=16'h0000` and `guess_valid` from 2 cycles after `start`; `busy=1`; `guess_count=1` after the handshake.
- Respond 16'h4a0b to the first guess: `solved=1`, `busy=0` next cycle, `guess_count=1`.
- Respond 16'h0a0b to 0000: next guess 16'h1111 after the scan.
- Reference model with secret 1234, looping:
  - `solved` within 10 guesses;
  - final guess 16'h1234;
  - every guess consistent with all prior responses.
- Respond 0a0b to every guess: guesses 0000, 1111, …, 9999, then `fail=1` (history full).
- Response 16'h3a2b: `fail=1`.
- `resp_valid` during OFFER and `start` while busy are both ignored.
- `rst` mid-SCAN: all outputs zero next cycle.
- With `SOLVER_DISTINCT_EN` defined: first guess 16'h0123.

Source files
------------

// File: rtl/solver_pkg.sv
// Shared types, response-word layout and BCD helpers for the bulls-and-cows guesser.
package solver_pkg;

  localparam int MAX_HIST_DEF = 10;
  localparam int A_MSB = 15;
  localparam int B_MSB = 7;
  localparam logic [3:0] MARK_A = 4'hA;
  localparam logic [3:0] MARK_B = 4'hB;

  typedef logic [3:0] bcd_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SCAN   = 3'd1,
    ST_OFFER  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_SOLVED = 3'd4,
    ST_FAIL   = 3'd5
  } state_t;

  // Returns {carry_out, value+1}; carry_out set when 9999 wraps to 0000.
  function automatic logic [16:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    bcd_t        dig;
    r = v;
    c = 1'b1;
    for (int d = 0; d < 4; d++) begin
      dig = v[4*d +: 4];
      if (!c) begin
        r[4*d +: 4] = dig;
      end else if (dig == 4'd9) begin
        r[4*d +: 4] = 4'd0;
      end else begin
        r[4*d +: 4] = dig + 4'd1;
        c = 1'b0;
      end
    end
    return {c, r};
  endfunction

  function automatic logic has_repeat(input logic [15:0] v);
    logic rep;
    rep = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int j = i + 1; j < 4; j++) begin
        rep = rep | (v[4*i +: 4] == v[4*j +: 4]);
      end
    end
    return rep;
  endfunction

endpackage

// File: rtl/score_1a2b.sv
// Combinational 1A2B scorer: A = positional matches, B = value matches among the non-bull digits.
module score_1a2b
  import solver_pkg::*;
(
  input  logic [15:0] i_guess,
  input  logic [15:0] i_cand,
  output logic [2:0]  o_a,
  output logic [2:0]  o_b
);

  logic [3:0] w_bull;
  logic [2:0] w_cg;
  logic [2:0] w_cc;
  bcd_t       w_gd;
  bcd_t       w_cd;

  // Bull mask first, then per-value min of leftover digit counts.
  always_comb begin
    o_a    = 3'd0;
    o_b    = 3'd0;
    w_bull = 4'd0;
    w_cg   = 3'd0;
    w_cc   = 3'd0;
    w_gd   = 4'd0;
    w_cd   = 4'd0;
    for (int d = 0; d < 4; d++) begin
      w_bull[d] = (i_guess[4*d +: 4] == i_cand[4*d +: 4]);
      o_a       = o_a + {2'b00, w_bull[d]};
    end
    for (int v = 0; v < 10; v++) begin
      w_cg = 3'd0;
      w_cc = 3'd0;
      for (int d = 0; d < 4; d++) begin
        w_gd = i_guess[4*d +: 4];
        w_cd = i_cand[4*d +: 4];
        if (!w_bull[d] && (w_gd == 4'(v))) w_cg = w_cg + 3'd1;
        else                               w_cg = w_cg;
        if (!w_bull[d] && (w_cd == 4'(v))) w_cc = w_cc + 3'd1;
        else                               w_cc = w_cc;
      end
      o_b = o_b + ((w_cg < w_cc) ? w_cg : w_cc);
    end
  end

endmodule

// File: rtl/bulls_cows_solver.sv
// Automatic 1A2B guesser: scans BCD candidates against the response history.
// Optional build macro SOLVER_DISTINCT_EN restricts candidates to four distinct digits.
module bulls_cows_solver
  import solver_pkg::*;
#(
  parameter int MAX_HIST = MAX_HIST_DEF
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_start,
  output logic        o_guess_valid,
  input  logic        i_guess_ready,
  output logic [15:0] o_guess,
  input  logic        i_resp_valid,
  input  logic [15:0] i_resp,
  output logic        o_busy,
  output logic        o_solved,
  output logic        o_fail,
  output logic [3:0]  o_guess_count
);

  localparam int IW = $clog2(MAX_HIST + 1);

  state_t          r_state;
  logic [15:0]     r_cand;
  logic [IW-1:0]   r_idx;
  logic [IW-1:0]   r_hist_cnt;
  logic [15:0]     r_hist_g [MAX_HIST];
  logic [2:0]      r_hist_a [MAX_HIST];
  logic [2:0]      r_hist_b [MAX_HIST];
  logic [15:0]     r_guess;
  logic            r_guess_valid;
  logic            r_busy;
  logic            r_solved;
  logic            r_fail;
  logic [3:0]      r_guess_cnt;

  logic [2:0]      w_a;
  logic [2:0]      w_b;
  logic            w_match;
  logic            w_reject;
  logic            w_dup;
  logic [16:0]     w_cand_inc;
  logic [16:0]     w_guess_inc;
  bcd_t            w_resp_a;
  bcd_t            w_resp_b;
  logic [4:0]      w_sum;
  logic            w_push;

  score_1a2b u_score (
    .i_guess (r_hist_g[r_idx]),
    .i_cand  (r_cand),
    .o_a     (w_a),
    .o_b     (w_b)
  );

`ifdef SOLVER_DISTINCT_EN
  assign w_dup = has_repeat(r_cand);
`else
  assign w_dup = 1'b0;
`endif

  // Candidate verdict and response decode.
  always_comb begin
    w_match     = (w_a == r_hist_a[r_idx]) && (w_b == r_hist_b[r_idx]);
    w_reject    = w_dup || ((r_hist_cnt != '0) && !w_match);
    w_cand_inc  = bcd_inc(r_cand);
    w_guess_inc = bcd_inc(r_guess);
    w_resp_a    = i_resp[A_MSB -: 4];
    w_resp_b    = i_resp[B_MSB -: 4];
    w_sum       = {1'b0, w_resp_a} + {1'b0, w_resp_b};
    if ((r_state == ST_WAIT) && i_resp_valid && (w_sum <= 5'd4) && (w_resp_a != 4'd4)) begin
      w_push = 1'b1;
    end else begin
      w_push = 1'b0;
    end
  end

  // History storage; validity is tracked by r_hist_cnt, so entries need no reset.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_hist_g[r_hist_cnt[IW-1:0]] <= r_guess;
      r_hist_a[r_hist_cnt[IW-1:0]] <= w_resp_a[2:0];
      r_hist_b[r_hist_cnt[IW-1:0]] <= w_resp_b[2:0];
    end
  end

  // Main control FSM with registered outputs.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state       <= ST_IDLE;
      r_cand        <= 16'h0000;
      r_idx         <= '0;
      r_hist_cnt    <= '0;
      r_guess       <= 16'h0000;
      r_guess_valid <= 1'b0;
      r_busy        <= 1'b0;
      r_solved      <= 1'b0;
      r_fail        <= 1'b0;
      r_guess_cnt   <= 4'd0;
    end else begin
      case (r_state)
        ST_IDLE, ST_SOLVED, ST_FAIL: begin
          if (i_start) begin
            r_state     <= ST_SCAN;
            r_hist_cnt  <= '0;
            r_guess_cnt <= 4'd0;
            r_solved    <= 1'b0;
            r_fail      <= 1'b0;
            r_cand      <= 16'h0000;
            r_idx       <= '0;
            r_busy      <= 1'b1;
          end
        end
        ST_SCAN: begin
          if (w_reject) begin
            if (w_cand_inc[16]) begin
              r_state <= ST_FAIL;
              r_fail  <= 1'b1;
              r_busy  <= 1'b0;
            end else begin
              r_cand <= w_cand_inc[15:0];
              r_idx  <= '0;
            end
          end else if ((r_hist_cnt == '0) || (r_idx == r_hist_cnt - IW'(1))) begin
            r_guess       <= r_cand;
            r_guess_valid <= 1'b1;
            r_state       <= ST_OFFER;
          end else begin
            r_idx <= r_idx + IW'(1);
          end
        end
        ST_OFFER: begin
          if (i_guess_ready) begin
            r_guess_cnt   <= r_guess_cnt + 4'd1;
            r_guess_valid <= 1'b0;
            r_state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (i_resp_valid) begin
            if (w_sum > 5'd4) begin
              r_state <= ST_FAIL;
              r_fail  <= 1'b1;
              r_busy  <= 1'b0;
            end else if (w_resp_a == 4'd4) begin
              r_state  <= ST_SOLVED;
              r_solved <= 1'b1;
              r_busy   <= 1'b0;
            end else begin
              r_hist_cnt <= r_hist_cnt + IW'(1);
              // Full history or exhausted candidate range both end the game.
              if ((r_hist_cnt == IW'(MAX_HIST - 1)) || w_guess_inc[16]) begin
                r_state <= ST_FAIL;
                r_fail  <= 1'b1;
                r_busy  <= 1'b0;
              end else begin
                r_cand  <= w_guess_inc[15:0];
                r_idx   <= '0;
                r_state <= ST_SCAN;
              end
            end
          end
        end
        default: begin
          r_state       <= ST_IDLE;
          r_guess_valid <= 1'b0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign o_guess_valid = r_guess_valid;
  assign o_guess       = r_guess;
  assign o_busy        = r_busy;
  assign o_solved      = r_solved;
  assign o_fail        = r_fail;
  assign o_guess_count = r_guess_cnt;

endmodule

// File: tb/tb_bulls_cows_solver.sv
// Self-checking bench for bulls_cows_solver: scoreboard of expected guesses plus an independent scorer.
module tb_bulls_cows_solver;

`ifdef SOLVER_DISTINCT_EN
  localparam logic [15:0] FIRST_G = 16'h0123;
`else
  localparam logic [15:0] FIRST_G = 16'h0000;
`endif
  localparam int WAIT_MAX = 30000;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_start;
  logic        o_guess_valid;
  logic        i_guess_ready;
  logic [15:0] o_guess;
  logic        i_resp_valid;
  logic [15:0] i_resp;
  logic        o_busy;
  logic        o_solved;
  logic        o_fail;
  logic [3:0]  o_guess_count;

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [15:0] exp_q[$];
  logic [15:0] hg[16];
  logic [7:0]  hr[16];
  int          hist_n;
  logic [15:0] g;
  logic [15:0] last_g;
  logic [7:0]  s;
  bit          ok;
  bit          done;

  bulls_cows_solver dut (
    .i_clk         (clk),
    .i_rst         (i_rst),
    .i_start       (i_start),
    .o_guess_valid (o_guess_valid),
    .i_guess_ready (i_guess_ready),
    .o_guess       (o_guess),
    .i_resp_valid  (i_resp_valid),
    .i_resp        (i_resp),
    .o_busy        (o_busy),
    .o_solved      (o_solved),
    .o_fail        (o_fail),
    .o_guess_count (o_guess_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
  endtask

  // Reference scorer: B = total common value count minus bulls.
  function automatic logic [7:0] ref_score(input logic [15:0] gg, input logic [15:0] cc);
    int ng[10];
    int nc[10];
    int a;
    int com;
    a = 0;
    com = 0;
    for (int v = 0; v < 10; v++) begin
      ng[v] = 0;
      nc[v] = 0;
    end
    for (int d = 0; d < 4; d++) begin
      if (gg[4*d +: 4] < 4'd10) ng[gg[4*d +: 4]]++;
      if (cc[4*d +: 4] < 4'd10) nc[cc[4*d +: 4]]++;
      if (gg[4*d +: 4] == cc[4*d +: 4]) a++;
    end
    for (int v = 0; v < 10; v++) com += (ng[v] < nc[v]) ? ng[v] : nc[v];
    return {4'(a), 4'(com - a)};
  endfunction

  task automatic wait_guess(output logic [15:0] gg, output bit okk);
    okk = 1'b0;
    gg  = 16'h0000;
    for (int i = 0; i < WAIT_MAX && !okk; i++) begin
      @(negedge clk);
      if (o_guess_valid === 1'b1) begin
        gg  = o_guess;
        okk = 1'b1;
      end
    end
  endtask

  // Wait for a guess and compare it against the scoreboard head when one is queued.
  task automatic next_guess(input string tag, output logic [15:0] gg, output bit okk);
    logic [15:0] e;
    wait_guess(gg, okk);
    if (!okk) check({tag, "_timeout"}, 32'd0, 32'd1);
    else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check(tag, {16'h0, gg}, {16'h0, e});
    end
  endtask

  // Called at the negedge just after a guess was seen with ready high: step into WAIT_RESP, then respond.
  task automatic respond(input logic [15:0] r);
    @(negedge clk);
    i_resp_valid = 1'b1;
    i_resp       = r;
    @(negedge clk);
    i_resp_valid = 1'b0;
  endtask

  task automatic start_game();
    @(negedge clk);
    i_start = 1'b1;
    exp_q.push_back(FIRST_G);
    @(negedge clk);
    i_start = 1'b0;
  endtask

  initial begin
    i_rst = 1'b1; i_start = 1'b0; i_guess_ready = 1'b1; i_resp_valid = 1'b0; i_resp = 16'h0;
    repeat (3) @(negedge clk);
    i_rst = 1'b0;
    check("rst_gv", {31'h0, o_guess_valid}, 32'd0);
    check("rst_guess", {16'h0, o_guess}, 32'd0);
    check("rst_busy", {31'h0, o_busy}, 32'd0);
    check("rst_flags", {30'h0, o_solved, o_fail}, 32'd0);
    check("rst_cnt", {28'h0, o_guess_count}, 32'd0);

    // First guess timing, then immediate solve.
`ifndef SOLVER_DISTINCT_EN
    @(negedge clk);
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    check("scan_gv", {31'h0, o_guess_valid}, 32'd0);
    check("scan_busy", {31'h0, o_busy}, 32'd1);
    @(negedge clk);
    check("first_gv", {31'h0, o_guess_valid}, 32'd1);
    check("first_guess", {16'h0, o_guess}, 32'h0000);
    @(negedge clk);
    check("hs_cnt", {28'h0, o_guess_count}, 32'd1);
    check("hs_gv", {31'h0, o_guess_valid}, 32'd0);
    i_resp_valid = 1'b1; i_resp = 16'h4a0b;
    @(negedge clk);
    i_resp_valid = 1'b0;
`else
    start_game();
    next_guess("first_guess", g, ok);
    respond(16'h4a0b);
`endif
    check("solve_flag", {31'h0, o_solved}, 32'd1);
    check("solve_busy", {31'h0, o_busy}, 32'd0);
    check("solve_cnt", {28'h0, o_guess_count}, 32'd1);
    check("solve_fail", {31'h0, o_fail}, 32'd0);

    // Ignored resp_valid in OFFER and start while busy, then 3A2B gives up.
    i_guess_ready = 1'b0;
    start_game();
    next_guess("hold_guess", g, ok);
    i_resp_valid = 1'b1; i_resp = 16'h4a0b;
    @(negedge clk);
    i_resp_valid = 1'b0;
    i_start = 1'b1;
    @(negedge clk);
    i_start = 1'b0;
    @(negedge clk);
    check("ign_solved", {31'h0, o_solved}, 32'd0);
    check("ign_gv", {31'h0, o_guess_valid}, 32'd1);
    check("ign_guess", {16'h0, o_guess}, {16'h0, FIRST_G});
    check("ign_cnt", {28'h0, o_guess_count}, 32'd0);
    i_guess_ready = 1'b1;
    respond(16'h3a2b);
    check("bad_fail", {31'h0, o_fail}, 32'd1);
    check("bad_busy", {31'h0, o_busy}, 32'd0);

    // Reset in the middle of a scan.
    start_game();
    next_guess("pre_rst_guess", g, ok);
    respond(16'h0a0b);
    repeat (2) @(negedge clk);
    check("midscan_busy", {31'h0, o_busy}, 32'd1);
    check("midscan_gv", {31'h0, o_guess_valid}, 32'd0);
    i_rst = 1'b1;
    @(negedge clk);
    i_rst = 1'b0;
    check("mrst_outs", {o_guess_valid, o_busy, o_solved, o_fail, o_guess_count, o_guess}, 32'd0);

    // Secret 1234 against the reference scorer.
    start_game();
    hist_n = 0; done = 1'b0; last_g = 16'h0;
    for (int k = 0; k < 10 && !done; k++) begin
      next_guess("g1234", g, ok);
      if (!ok) done = 1'b1;
      else begin
        for (int j = 0; j < hist_n; j++) check("consistent", {24'h0, ref_score(g, hg[j])}, {24'h0, hr[j]});
        s = ref_score(g, 16'h1234);
        hg[hist_n] = g; hr[hist_n] = s; hist_n++;
        last_g = g;
        respond({s[7:4], 4'hA, s[3:0], 4'hB});
        if (s[7:4] == 4'd4) done = 1'b1;
      end
    end
    check("s1234_solved", {31'h0, o_solved}, 32'd1);
    check("s1234_last", {16'h0, last_g}, 32'h1234);
    check("s1234_cnt", {28'h0, o_guess_count}, hist_n);

`ifndef SOLVER_DISTINCT_EN
    // All-miss responses walk 0000,1111,...,9999 and exhaust the history.
    start_game();
    done = 1'b0;
    for (int k = 0; k < 10 && !done; k++) begin
      next_guess("walk", g, ok);
      if (!ok) done = 1'b1;
      else begin
        if (k < 9) exp_q.push_back(g + 16'h1111);
        respond(16'h0a0b);
      end
    end
    check("walk_fail", {31'h0, o_fail}, 32'd1);
    check("walk_busy", {31'h0, o_busy}, 32'd0);
    check("walk_cnt", {28'h0, o_guess_count}, 32'd10);
    check("walk_q_empty", exp_q.size(), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
